// File: rtl/rr_arb2.sv
// Two-way round-robin winner pick: a lone requester wins, a tie goes to the port not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is sampled.
module rr_arb2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_gnt,
    output logic winner
);

    // winner/last_gnt encoding: 0 = A, 1 = B
    always_comb begin
        winner = 1'b0;
        if (req_a && req_b) begin
            winner = ~last_gnt;
        end else if (req_b) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/sync_mem_arbiter.sv
// Shares one synchronous memory between two requesters through an IDLE/ISSUE/DONE handshake.
// Latency: req seen in IDLE -> mem_cs next cycle -> ack the cycle after; one access per 3 cycles.
// Backpressure: requesters hold req until ack; requests are only sampled in IDLE.
module sync_mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_a,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    state_t state;
    logic   gnt;
    logic   last_gnt;
    logic   winner;
    logic   in_issue;
    logic   in_done;

    rr_arb2 u_rr_arb2 (
        .req_a    (req_a),
        .req_b    (req_b),
        .last_gnt (last_gnt),
        .winner   (winner)
    );

    // last_gnt resets to B so that A wins the first contended arbitration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= GNT_A;
            last_gnt <= GNT_B;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        state    <= ISSUE;
                        gnt      <= winner;
                        last_gnt <= winner;
                    end
                end
                ISSUE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from the async-reset state so reset drops cs/ack within the cycle
    assign in_issue  = (state == ISSUE);
    assign in_done   = (state == DONE);
    assign busy      = (state != IDLE);
    assign mem_cs    = in_issue;
    assign mem_we    = in_issue & ((gnt == GNT_B) ? we_b : we_a);
    assign mem_addr  = in_issue ? ((gnt == GNT_B) ? addr_b : addr_a) : '0;
    assign mem_wdata = in_issue ? ((gnt == GNT_B) ? wdata_b : wdata_a) : '0;
    assign ack_a     = in_done & (gnt == GNT_A);
    assign ack_b     = in_done & (gnt == GNT_B);
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_sync_mem_arbiter.sv
// Bench for sync_mem_arbiter: schedule-based reference model plus directed scenarios.
module tb_sync_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a, we_a, req_b, we_b;
    logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
    logic       ack_a, ack_b, busy, mem_cs, mem_we;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    sync_mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a),
        .req_b     (req_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .wdata_b   (wdata_b),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .rdata     (rdata),
        .busy      (busy),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered synchronous memory driven by the DUT
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each access is a schedule (cs in cycle start, ack in start+1, free after)
    int         cyc = 0;
    bit         m_active = 1'b0;
    bit         m_last = 1'b1;
    bit         m_port, m_we;
    logic [7:0] m_addr, m_wdata;
    int         m_start = 0;
    logic [7:0] mmem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'h00;
            mmem[i] = 8'h00;
        end
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0;
                m_last   = 1'b1;
            end else begin
                cyc++;
                if (m_active && cyc == m_start + 1 && m_we) mmem[m_addr] = m_wdata;
                if (m_active && cyc == m_start + 2) begin
                    m_active = 1'b0;
                end else if (!m_active && (req_a || req_b)) begin
                    m_port   = (req_a && req_b) ? !m_last : req_b;
                    m_last   = m_port;
                    m_we     = m_port ? we_b : we_a;
                    m_addr   = m_port ? addr_b : addr_a;
                    m_wdata  = m_port ? wdata_b : wdata_a;
                    m_start  = cyc;
                    m_active = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    bit prev_cs = 1'b0;
    initial begin
        forever begin
            bit e_cs, e_ack;
            @(posedge clk);
            #2;
            e_cs  = m_active && (cyc == m_start);
            e_ack = m_active && (cyc == m_start + 1);
            check("busy", busy, m_active);
            check("mem_cs", mem_cs, e_cs);
            check("mem_we", mem_we, e_cs && m_we);
            check("mem_addr", mem_addr, e_cs ? m_addr : 8'h00);
            check("mem_wdata", mem_wdata, e_cs ? m_wdata : 8'h00);
            check("ack_a", ack_a, e_ack && !m_port);
            check("ack_b", ack_b, e_ack && m_port);
            if (e_ack && !m_we) check("rdata", rdata, mmem[m_addr]);
            check("ack_exclusive", ack_a & ack_b, 0);
            check("cs_consecutive", mem_cs & prev_cs, 0);
            prev_cs = mem_cs;
        end
    end

    task automatic access(input logic port, input logic we, input logic [7:0] addr,
                          input logic [7:0] wd, output logic [7:0] rd);
        @(negedge clk);
        if (port) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
        end
        @(posedge clk); #2;
        check("acc_cs", mem_cs, 1);
        check("acc_we", mem_we, we);
        check("acc_addr", mem_addr, addr);
        @(posedge clk); #2;
        check("acc_ack", port ? ack_b : ack_a, 1);
        rd = rdata;
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        logic [5:0] order;
        int         n;
        int         acks;
        int         ack_cyc;

        rst = 1'b1;
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_cs", mem_cs, 0);
        check("rst_acks", {ack_a, ack_b}, 0);
        check("rst_addr", mem_addr, 0);
        @(negedge clk) rst = 1'b0;

        // Write then read back through the other port
        access(1'b0, 1'b1, 8'h10, 8'hA5, rd);
        access(1'b1, 1'b0, 8'h10, 8'h00, rd);
        check("t1_rdata", rd, 8'hA5);

        // Contention right after reset: A then B
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_a = 1; addr_a = 8'h30; req_b = 1; addr_b = 8'h31;
        @(posedge clk); #2;
        check("t2_c1_cs", mem_cs, 1);
        check("t2_c1_addr", mem_addr, 8'h30);
        @(posedge clk); #2;
        check("t2_c2_ack", {ack_a, ack_b}, 2'b10);
        @(negedge clk) req_a = 0;
        @(posedge clk); #2;
        check("t2_c3_busy", busy, 0);
        @(posedge clk); #2;
        check("t2_c4_cs", mem_cs, 1);
        check("t2_c4_addr", mem_addr, 8'h31);
        @(posedge clk); #2;
        check("t2_c5_ack", {ack_a, ack_b}, 2'b01);
        @(negedge clk) req_b = 0;

        // Continuous contention: strict alternation starting with A
        @(negedge clk);
        req_a = 1; addr_a = 8'h40; req_b = 1; addr_b = 8'h41;
        n = 0;
        order = '0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(posedge clk); #2;
            if (ack_a || ack_b) begin
                order[n] = ack_b;
                n++;
            end
        end
        @(negedge clk);
        req_a = 0; req_b = 0;
        check("t3_count", n, 6);
        check("t3_order", order, 6'b101010);

        // Top-of-range address
        access(1'b0, 1'b1, 8'hFF, 8'h3C, rd);
        access(1'b0, 1'b0, 8'hFF, 8'h00, rd);
        check("t4_rdata", rd, 8'h3C);

        // Reset in the middle of a B write
        @(negedge clk);
        req_b = 1; we_b = 1; addr_b = 8'h20; wdata_b = 8'h77;
        @(posedge clk); #2;
        check("t5_cs_before", mem_cs, 1);
        #1 rst = 1'b1;
        #1;
        check("t5_cs_async", mem_cs, 0);
        check("t5_busy_async", busy, 0);
        check("t5_ackb_async", ack_b, 0);
        @(negedge clk);
        req_b = 0; we_b = 0;
        @(posedge clk); #2;
        check("t5_no_ack", ack_b, 0);
        @(negedge clk);
        rst = 1'b0;
        req_a = 1; addr_a = 8'h50; req_b = 1; addr_b = 8'h51;
        @(posedge clk); #2;
        check("t5_grant_a_addr", mem_addr, 8'h50);
        @(posedge clk); #2;
        check("t5_grant_a_ack", {ack_a, ack_b}, 2'b10);
        @(negedge clk);
        req_a = 0; req_b = 0;
        access(1'b1, 1'b0, 8'h20, 8'h00, rd);
        check("t5_write_lost", rd, 8'h00);

        // Request withdrawn during ISSUE still completes once
        @(negedge clk);
        req_a = 1; we_a = 0; addr_a = 8'h10;
        @(posedge clk); #2;
        check("t6_cs", mem_cs, 1);
        @(negedge clk) req_a = 0;
        acks = 0;
        ack_cyc = -1;
        for (int c = 2; c <= 7; c++) begin
            @(posedge clk); #2;
            if (ack_a) begin
                acks++;
                ack_cyc = c;
                check("t6_rdata", rdata, 8'hA5);
            end
        end
        check("t6_ack_count", acks, 1);
        check("t6_ack_cycle", ack_cyc, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
